// File: rtl/instruction_queue_pkg.sv
// Shared types and constants for the instruction queue: entry layout and default depth.
package instruction_queue_pkg;

    localparam int IQ_DEPTH      = 8;
    localparam int IQ_ADDR_WIDTH = 32;
    localparam int IQ_DATA_WIDTH = 32;

    typedef struct packed {
        logic [IQ_ADDR_WIDTH-1:0] addr;
        logic [IQ_DATA_WIDTH-1:0] instr;
        logic                     pred_taken;
        logic [IQ_ADDR_WIDTH-1:0] pred_target;
    } iq_entry_t;

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/instruction_queue.sv
// Two-in / two-out circular instruction buffer between fetch and decode.
// Flush or reset empties the queue in one cycle; storage itself is never cleared.
module instruction_queue
    import instruction_queue_pkg::*;
#(
    parameter int ADDR_WIDTH = IQ_ADDR_WIDTH,
    parameter int DATA_WIDTH = IQ_DATA_WIDTH,
    parameter int DEPTH      = IQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [1:0]                 enq_valid,
    input  logic [ADDR_WIDTH-1:0]      enq_addr_0,
    input  logic [ADDR_WIDTH-1:0]      enq_addr_1,
    input  logic [DATA_WIDTH-1:0]      enq_instr_0,
    input  logic [DATA_WIDTH-1:0]      enq_instr_1,
    input  logic                       enq_pred_taken_0,
    input  logic                       enq_pred_taken_1,
    input  logic [ADDR_WIDTH-1:0]      enq_pred_target_0,
    input  logic [ADDR_WIDTH-1:0]      enq_pred_target_1,
    output logic                       enq_ready,
    output logic [1:0]                 deq_valid,
    output logic [ADDR_WIDTH-1:0]      deq_addr_0,
    output logic [ADDR_WIDTH-1:0]      deq_addr_1,
    output logic [DATA_WIDTH-1:0]      deq_instr_0,
    output logic [DATA_WIDTH-1:0]      deq_instr_1,
    output logic                       deq_pred_taken_0,
    output logic                       deq_pred_taken_1,
    output logic [ADDR_WIDTH-1:0]      deq_pred_target_0,
    output logic [ADDR_WIDTH-1:0]      deq_pred_target_1,
    input  logic [1:0]                 deq_accept,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    iq_entry_t       r_mem [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    logic            w_enq_ready;
    logic            w_enq_fire;
    logic [1:0]      w_enq_n;
    logic [1:0]      w_acc;
    logic [1:0]      w_deq_n;
    logic [PW-1:0]   w_tail_p1;
    logic [PW-1:0]   w_head_p1;
    iq_entry_t       w_slot0;
    iq_entry_t       w_slot1;
    iq_entry_t       w_wr0;
    iq_entry_t       w_head0;
    iq_entry_t       w_head1;

    // Handshake: enq_ready reflects only the registered count, so a pair is taken
    // iff enq_ready && enq_valid != 0 at the edge; decode consumes min(deq_accept, count).
    assign w_enq_ready = (r_count <= CW'(DEPTH - 2));
    assign w_enq_fire  = w_enq_ready && (enq_valid != 2'b00);
    assign w_enq_n     = w_enq_fire ? popcount2(enq_valid) : 2'd0;
    assign w_acc       = (deq_accept == 2'b11) ? 2'd2 : deq_accept;
    assign w_deq_n     = ({{(CW-2){1'b0}}, w_acc} > r_count) ? r_count[1:0] : w_acc;

    assign w_tail_p1 = r_tail + PW'(1);
    assign w_head_p1 = r_head + PW'(1);

    assign w_slot0 = '{addr: enq_addr_0, instr: enq_instr_0,
                       pred_taken: enq_pred_taken_0, pred_target: enq_pred_target_0};
    assign w_slot1 = '{addr: enq_addr_1, instr: enq_instr_1,
                       pred_taken: enq_pred_taken_1, pred_target: enq_pred_target_1};
    // Valid slots are compacted: a lone slot 1 lands at tail, not tail+1.
    assign w_wr0   = enq_valid[0] ? w_slot0 : w_slot1;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_deq_n);
            r_tail  <= r_tail + PW'(w_enq_n);
            r_count <= r_count + CW'(w_enq_n) - CW'(w_deq_n);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && w_enq_fire) begin
            r_mem[r_tail] <= w_wr0;
            if (enq_valid == 2'b11) begin
                r_mem[w_tail_p1] <= w_slot1;
            end
        end
    end

    assign w_head0 = r_mem[r_head];
    assign w_head1 = r_mem[w_head_p1];

    assign enq_ready         = w_enq_ready;
    assign deq_valid         = {(r_count >= CW'(2)), (r_count != '0)};
    assign deq_addr_0        = w_head0.addr;
    assign deq_addr_1        = w_head1.addr;
    assign deq_instr_0       = w_head0.instr;
    assign deq_instr_1       = w_head1.instr;
    assign deq_pred_taken_0  = w_head0.pred_taken;
    assign deq_pred_taken_1  = w_head1.pred_taken;
    assign deq_pred_target_0 = w_head0.pred_target;
    assign deq_pred_target_1 = w_head1.pred_target;
    assign count             = r_count;

endmodule
